// File: rtl/uart_rx_frame_check.sv
// UART receive frame checker: consumes one mid-bit sample per bit period and
// walks the frame (start, data, optional parity, one or two stops), reporting
// the received word with parity/stop/break status and a saturating error count.
module uart_rx_frame_check #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  bit_vld,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stp_num,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_vld,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  brk_det,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  typedef enum logic [2:0] {StIdle, StData, StParity, StStop1, StStop2} state_e;

  state_e                state_q, state_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  // Frame configuration captured at the start bit
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  stp_num_q, stp_num_d;
  // Parity result and raw parity bit, held until the frame closes
  logic                  par_err_pend_q, par_err_pend_d;
  logic                  par_bit_q, par_bit_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_vld_q, data_vld_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  brk_det_q, brk_det_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

  logic                  frame_end;
  logic                  stp_err_nxt;
  logic                  brk_nxt;

  // Next-state: frame walk, status capture at frame end, error counter
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    par_en_d       = par_en_q;
    par_typ_d      = par_typ_q;
    stp_num_d      = stp_num_q;
    par_err_pend_d = par_err_pend_q;
    par_bit_d      = par_bit_q;
    p_data_d       = p_data_q;
    data_vld_d     = 1'b0;
    par_err_d      = par_err_q;
    stp_err_d      = stp_err_q;
    brk_det_d      = brk_det_q;
    err_cnt_d      = err_cnt_q;
    frame_end      = 1'b0;
    stp_err_nxt    = 1'b0;
    brk_nxt        = 1'b0;

    if (bit_vld) begin
      unique case (state_q)
        StIdle: begin
          if (!sampled_bit) begin
            state_d        = StData;
            bit_cnt_d      = '0;
            shift_d        = '0;
            par_en_d       = par_en;
            par_typ_d      = par_typ;
            stp_num_d      = stp_num;
            par_err_pend_d = 1'b0;
            par_bit_d      = 1'b0;
          end
        end
        StData: begin
          shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? StParity : StStop1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        StParity: begin
          par_bit_d      = sampled_bit;
          par_err_pend_d = sampled_bit != (^shift_q ^ par_typ_q);
          state_d        = StStop1;
        end
        StStop1: begin
          if (!sampled_bit) begin
            // Skip STOP2 on a bad first stop so the line can resync
            frame_end   = 1'b1;
            stp_err_nxt = 1'b1;
            brk_nxt     = (shift_q == '0) && !(par_en_q && par_bit_q);
          end else if (stp_num_q) begin
            state_d = StStop2;
          end else begin
            frame_end = 1'b1;
          end
        end
        StStop2: begin
          frame_end   = 1'b1;
          stp_err_nxt = !sampled_bit;
        end
        default: state_d = StIdle;
      endcase
    end

    if (frame_end) begin
      state_d    = StIdle;
      data_vld_d = 1'b1;
      p_data_d   = shift_q;
      par_err_d  = par_en_q & par_err_pend_q;
      stp_err_d  = stp_err_nxt;
      brk_det_d  = brk_nxt;
    end

    // A clear landing on an erroring frame end still counts that frame
    if (frame_end && ((par_en_q & par_err_pend_q) | stp_err_nxt)) begin
      if (err_clr) begin
        err_cnt_d = CNT_WIDTH'(1);
      end else if (err_cnt_q != CntMax) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end else if (err_clr) begin
      err_cnt_d = '0;
    end
  end

  // State and status registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= StIdle;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      stp_num_q      <= 1'b0;
      par_err_pend_q <= 1'b0;
      par_bit_q      <= 1'b0;
      p_data_q       <= '0;
      data_vld_q     <= 1'b0;
      par_err_q      <= 1'b0;
      stp_err_q      <= 1'b0;
      brk_det_q      <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      par_en_q       <= par_en_d;
      par_typ_q      <= par_typ_d;
      stp_num_q      <= stp_num_d;
      par_err_pend_q <= par_err_pend_d;
      par_bit_q      <= par_bit_d;
      p_data_q       <= p_data_d;
      data_vld_q     <= data_vld_d;
      par_err_q      <= par_err_d;
      stp_err_q      <= stp_err_d;
      brk_det_q      <= brk_det_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign p_data   = p_data_q;
  assign data_vld = data_vld_q;
  assign par_err  = par_err_q;
  assign stp_err  = stp_err_q;
  assign brk_det  = brk_det_q;
  assign busy     = (state_q != StIdle);
  assign err_cnt  = err_cnt_q;

endmodule

// File: doc/uart_rx_frame_check.md
Name: uart_rx_frame_check

Overview:
- Parametrised UART-RX frame checker.
- Consumes the mid-bit sampled line value, one strobe per bit period, and tracks the whole frame: start, data, optional parity, one or two stop bits.
- Emits the deserialised data word with per-frame parity, stop and break status, plus a saturating error-frame counter.
- Sits between the RX data sampler and the RX-to-system synchroniser; generalises the single-bit stop check to full-frame checking.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- CNT_WIDTH, 8, width of the error-frame counter.

Ports:
- CLK  input  1  receiver oversampling-domain clock.
- RST  input  1  asynchronous, active-low reset.
- bit_vld  input  1  one-CLK strobe; sampled_bit is valid this cycle.
- sampled_bit  input  1  majority-voted line value for the current bit.
- par_en  input  1  parity bit present.
- par_typ  input  1  parity type: 0 = even, 1 = odd.
- stp_num  input  1  stop bits: 0 = one stop bit, 1 = two stop bits.
- err_clr  input  1  synchronous clear of err_cnt.
- p_data  output  DATA_WIDTH  received word, LSB received first.
- data_vld  output  1  one-CLK pulse at end of each frame.
- par_err  output  1  parity mismatch for the last frame.
- stp_err  output  1  stop bit sampled 0 in the last frame.
- brk_det  output  1  break detected in the last frame.
- busy  output  1  a frame is in progress.
- err_cnt  output  CNT_WIDTH  saturating count of frames with par_err or stp_err.

Behaviour:
- Reset (RST low, asynchronous): state IDLE, bit counter 0, all outputs 0.
- All state advances only on cycles with bit_vld=1. Cycles with bit_vld=0 hold every register, except that data_vld returns to 0.
- States:
  - IDLE: on bit_vld with sampled_bit=0, the start bit is accepted. Latch par_en, par_typ and stp_num into shadow registers; clear the shift register; go to DATA; busy=1. sampled_bit=1 keeps the block in IDLE.
  - DATA: shift sampled_bit in LSB-first and increment the bit counter. After bit DATA_WIDTH-1, go to PARITY if shadow par_en=1, else go to STOP1.
  - PARITY: expected = XOR of data bits XOR shadow par_typ. par_err_next = (sampled_bit != expected). Go to STOP1.
  - STOP1: if sampled_bit=0, set stp_err_next=1 and end the frame immediately; STOP2 is skipped so the line can resync. If sampled_bit=1 and shadow stp_num=1, go to STOP2. Otherwise end the frame.
  - STOP2: stp_err_next = ~sampled_bit; end the frame.
- Frame end, registered on the same edge that samples the final bit, so visible in the next cycle:
  - p_data, par_err, stp_err and brk_det are updated.
  - data_vld=1 for exactly one CLK.
  - busy=0; return to IDLE.
  - par_err is 0 when parity is disabled.
- Status hold: p_data and the status flags hold until the next frame end. They do not change at the next start bit.
- brk_det=1 when all data bits are 0, the parity bit is 0 (if present) and STOP1 is 0. A break frame also sets stp_err.
- Config changes mid-frame (par_en, par_typ, stp_num) have no effect until the next start bit.
- err_cnt:
  - Increments by 1 at a frame end with par_err_next | stp_err_next.
  - Saturates at 2^CNT_WIDTH-1.
  - err_clr=1 clears it to 0.
  - err_clr coincident with an erroring frame end yields 1.
- Minimum frame: 1+DATA_WIDTH bit strobes plus one stop strobe. A back-to-back start bit on the strobe immediately after frame end is accepted.
- Reset mid-frame discards the partial frame. No data_vld is produced for it.

Test Plan:
1. DATA_WIDTH=8, par_en=0, stp_num=0; send 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> p_data=0xA5, data_vld single pulse, par_err=0, stp_err=0, err_cnt=0.
2. par_en=1, par_typ=0; send 0x07 with parity bit 1, then 0x07 with parity bit 0 -> first frame par_err=0; second frame par_err=1, err_cnt=1.
3. stp_num=1; send 0x3C with stop bits 1,0 -> stp_err=1, err_cnt increments. Then send with STOP1=0 -> frame ends after STOP1 (1+8+1 strobes), stp_err=1.
4. Line held 0 for 10 strobes -> p_data=0x00, brk_det=1, stp_err=1. Next good frame 0x55 -> brk_det=0, stp_err=0.
5. CNT_WIDTH=2; send 5 parity-error frames -> err_cnt saturates at 3. Assert err_clr together with a 6th error frame end -> err_cnt=1.
6. Assert RST low after 4 data bits, release, then send 0x81 -> no data_vld for the aborted frame; 0x81 received cleanly. Toggle par_en mid-frame -> the current frame uses the setting latched at its start bit.
